keypad_scan: RTL and testbench

Parametrised matrix-keypad scanner for the GPIO subsystem. Drives one active-low column at a time and samples active-low rows. Applies per-key frame-based debouncing and publishes a debounced key bitmap. Optionally queues press/release events in a FIFO for the CPU-side GPIO register block.

---
 rtl/keypad_scan.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - Matrix keypad scanner with frame debounce; event FIFO when KEYPAD_SCAN_EVENT_FIFO_EN is defined
module keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CLK_DIV    = 100,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int K         = ROWS * COLS,
  localparam int CW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] keypad_row,
  output logic [COLS-1:0] keypad_col,
  output logic [K-1:0]    keys,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_press,
  output logic [CW-1:0]   evt_code,
  output logic            evt_overflow
);

  localparam int DW   = $clog2(CLK_DIV);
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
    DISPATCH = 2'd2,
`endif
    SCAN     = 2'd0,
    COMMIT   = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q;
  logic [COLW-1:0] col_idx_q;
  logic [K-1:0]    raw_q;
  logic            frame_done_q;
  logic [K-1:0]    keys_q;
  logic [3:0]      db_cnt_q [K];
  logic [K-1:0]    flip;
  logic            tick;

  assign tick       = (div_cnt_q == DW'(CLK_DIV - 1));
  assign keypad_col = ~(COLS'(1) << col_idx_q);
  assign keys       = keys_q;

  // Column divider: sample the driven column on each tick, then step to the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      col_idx_q    <= '0;
      raw_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (tick) begin
        div_cnt_q <= '0;
        for (int c = 0; c < COLS; c++) begin
          if (col_idx_q == COLW'(c)) raw_q[c*ROWS +: ROWS] <= ~keypad_row;
        end
        if (col_idx_q == COLW'(COLS - 1)) begin
          col_idx_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          col_idx_q <= col_idx_q + COLW'(1);
        end
      end else begin
        div_cnt_q <= div_cnt_q + DW'(1);
      end
    end
  end

  // Keys that have disagreed with their stable state for DEBOUNCE frames including this one
  always_comb begin
    flip = '0;
    for (int k = 0; k < K; k++) begin
      flip[k] = (raw_q[k] != keys_q[k]) && (db_cnt_q[k] == 4'(DEBOUNCE - 1));
    end
  end

  // Debounce commit: once per frame, flip settled keys and advance or clear counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_q <= '0;
      for (int k = 0; k < K; k++) db_cnt_q[k] <= '0;
    end else if (state_q == COMMIT) begin
      keys_q <= keys_q ^ flip;
      for (int k = 0; k < K; k++) begin
        if ((raw_q[k] == keys_q[k]) || flip[k]) db_cnt_q[k] <= '0;
        else                                    db_cnt_q[k] <= db_cnt_q[k] + 4'd1;
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SCAN;
    else      state_q <= state_d;
  end

`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CW-1:0] disp_idx_q;
  logic [K-1:0]  chg_q;
  logic [CW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW:0]   head;
  logic          push_req, full, pop, do_push, overflow_q;

  // Next state: a frame commits, then every key index is visited once for events
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (frame_done_q) state_d = COMMIT;
      COMMIT:   state_d = DISPATCH;
      DISPATCH: if (disp_idx_q == CW'(K - 1)) state_d = SCAN;
      default:  state_d = SCAN;
    endcase
  end

  // Change flags: raised on a committed flip, cleared as dispatch passes each key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       chg_q <= '0;
    else if (state_q == COMMIT)     chg_q <= chg_q | flip;
    else if (state_q == DISPATCH)   chg_q[disp_idx_q] <= 1'b0;
  end

  // Dispatch index walks 0..K-1 in ascending order so lower codes queue first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) disp_idx_q <= '0;
    else if (state_q == DISPATCH)
      disp_idx_q <= (disp_idx_q == CW'(K - 1)) ? '0 : disp_idx_q + CW'(1);
  end

  assign push_req = (state_q == DISPATCH) && chg_q[disp_idx_q];
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = evt_valid && evt_ready;
  assign do_push  = push_req && (!full || pop);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // Event storage; contents only matter behind a valid read pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {keys_q[disp_idx_q], disp_idx_q};
  end

  // FIFO pointers and drop pulse; a pop frees the slot for a same-cycle push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      overflow_q <= push_req && full && !pop;
    end
  end

  assign evt_valid    = (wr_ptr_q != rd_ptr_q);
  assign evt_press    = evt_valid & head[CW];
  assign evt_code     = evt_valid ? head[CW-1:0] : '0;
  assign evt_overflow = overflow_q;
`else
  logic unused_evt_ready;

  // Next state: commit returns straight to scanning
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (frame_done_q) state_d = COMMIT;
      COMMIT:  state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  assign unused_evt_ready = evt_ready;
  assign evt_valid        = 1'b0;
  assign evt_press        = 1'b0;
  assign evt_code         = '0;
  assign evt_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - Table-driven scoreboard bench for keypad_scan
module tb_keypad_scan;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } evt_t;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    logic        ready;
    logic [15:0] exp_keys;
    bit          gap_chk;
  } step_t;

  logic        clk;
  logic        rst;
  logic [3:0]  keypad_row;
  logic [3:0]  keypad_col;
  logic [15:0] keys;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_press;
  logic [3:0]  evt_code;
  logic        evt_overflow;

  logic [15:0] pressed;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ovf_seen = 0;
  int          exp_ovf  = 0;
  int          cycle    = 0;
  evt_t        exp_q[$];
  int          evt_cyc_q[$];
  step_t       steps[$];
  logic        hold_q = 1'b0;
  logic [4:0]  held   = '0;

  keypad_scan #(
    .ROWS(4), .COLS(4), .CLK_DIV(100), .DEBOUNCE(3), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .keypad_row(keypad_row), .keypad_col(keypad_col),
    .keys(keys), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_press(evt_press), .evt_code(evt_code), .evt_overflow(evt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Passive matrix: a row reads low when a pressed key sits on the driven column
  always_comb begin
    keypad_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!keypad_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[c*4 + r]) keypad_row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_frame();
    logic [3:0] prev;
    int  n;
    bit  done;
    prev = keypad_col;
    n    = 0;
    done = 1'b0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      if (keypad_col == 4'b1110 && prev == 4'b0111) done = 1'b1;
      prev = keypad_col;
    end
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL frame_sync: got no column wrap after %0d cycles, expected one within 600", n);
    end
  endtask

  // Scoreboard monitor: pops expected events on handshake, checks head stability and counts drops
  always @(negedge clk) begin
    if (rst) begin
      if (evt_overflow) ovf_seen++;
`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
      if (hold_q) check("evt_hold", {27'd0, evt_valid, evt_press, evt_code}, {27'd0, 1'b1, held});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL evt_unexpected: got press=%0d code=%0d expected no event", evt_press, evt_code);
        end else begin
          evt_t e;
          e = exp_q.pop_front();
          check("evt_press", 32'(evt_press), 32'(e.press));
          check("evt_code", 32'(evt_code), 32'(e.code));
          evt_cyc_q.push_back(cycle);
        end
      end
`endif
      hold_q = evt_valid && !evt_ready;
      held   = {evt_press, evt_code};
    end else begin
      hold_q = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected test end", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_keys;
    logic [3:0]  one;
    logic [3:0]  exp_col;

    steps.push_back('{16'h0200, 2, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h0200, 1, 1'b1, 16'h0200, 1'b0});
    steps.push_back('{16'h0000, 2, 1'b1, 16'h0200, 1'b0});
    steps.push_back('{16'h0000, 1, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h0001, 2, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h0000, 1, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h0001, 2, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h0000, 3, 1'b1, 16'h0000, 1'b0});
    steps.push_back('{16'h1020, 3, 1'b1, 16'h1020, 1'b1});
    steps.push_back('{16'h0000, 3, 1'b1, 16'h0000, 1'b0});
    for (int t = 0; t < 5; t++) begin
      steps.push_back('{16'h0008, 3, 1'b0, 16'h0008, 1'b0});
      steps.push_back('{16'h0000, 3, 1'b0, 16'h0000, 1'b0});
    end

    rst       = 1'b0;
    pressed   = 16'h0000;
    evt_ready = 1'b1;
    step_cycles(3);
    check("rst_col", 32'(keypad_col), 32'h0E);
    check("rst_keys", 32'(keys), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_press", 32'(evt_press), 32'h0);
    check("rst_code", 32'(evt_code), 32'h0);
    check("rst_ovf", 32'(evt_overflow), 32'h0);

    rst = 1'b1;
    one = 4'b0001;
    for (int p = 1; p <= 450; p++) begin
      @(posedge clk);
      #1;
      if (p % 100 == 50) begin
        exp_col = ~(one << ((p / 100) % 4));
        check($sformatf("col_walk_%0d", p), 32'(keypad_col), 32'(exp_col));
        check("idle_keys", 32'(keys), 32'h0);
        check("idle_valid", 32'(evt_valid), 32'h0);
      end
    end

    wait_frame();
    step_cycles(2);
    prev_keys = 16'h0000;
    foreach (steps[i]) begin
      pressed   = steps[i].mask;
      evt_ready = steps[i].ready;
      evt_cyc_q.delete();
`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
      for (int k = 0; k < 16; k++) begin
        if (steps[i].exp_keys[k] != prev_keys[k]) begin
          if (exp_q.size() < 8) exp_q.push_back('{press: steps[i].exp_keys[k], code: 4'(k)});
          else                  exp_ovf++;
        end
      end
`endif
      prev_keys = steps[i].exp_keys;
      repeat (steps[i].frames) wait_frame();
      step_cycles(30);
      check($sformatf("keys_step%0d", i), 32'(keys), 32'(steps[i].exp_keys));
`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
      if (steps[i].ready) check($sformatf("evt_pending_step%0d", i), 32'(exp_q.size()), 32'h0);
      if (steps[i].gap_chk) begin
        check("multi_evt_count", 32'(evt_cyc_q.size()), 32'd2);
        if (evt_cyc_q.size() == 2) check("multi_evt_gap", 32'(evt_cyc_q[1] - evt_cyc_q[0]), 32'd7);
      end
`else
      check($sformatf("evt_valid_off_step%0d", i), 32'(evt_valid), 32'h0);
`endif
    end

`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
    check("ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
    check("ovf_head", {27'd0, evt_valid, evt_press, evt_code}, {27'd0, 1'b1, 1'b1, 4'd3});
    for (int i = 0; i < 60; i++) begin
      evt_ready = 1'($urandom_range(0, 1));
      step_cycles(1);
    end
    evt_ready = 1'b1;
    step_cycles(20);
    check("drain_pending", 32'(exp_q.size()), 32'h0);
    check("drain_valid", 32'(evt_valid), 32'h0);
`else
    check("ovf_off", 32'(ovf_seen), 32'h0);
`endif

    evt_ready = 1'b0;
    wait_frame();
    step_cycles(1);
    pressed = 16'h8001;
    repeat (3) wait_frame();
    step_cycles(6);
    check("mid_keys", 32'(keys), 32'h8001);
`ifdef KEYPAD_SCAN_EVENT_FIFO_EN
    check("mid_head", {27'd0, evt_valid, evt_press, evt_code}, {27'd0, 1'b1, 1'b1, 4'd0});
`endif
    rst     = 1'b0;
    pressed = 16'h0000;
    step_cycles(2);
    check("mid_rst_keys", 32'(keys), 32'h0);
    check("mid_rst_valid", 32'(evt_valid), 32'h0);
    check("mid_rst_col", 32'(keypad_col), 32'h0E);
    check("mid_rst_code", 32'(evt_code), 32'h0);
    rst       = 1'b1;
    evt_ready = 1'b1;
    repeat (4) wait_frame();
    step_cycles(30);
    check("post_rst_keys", 32'(keys), 32'h0);
    check("post_rst_valid", 32'(evt_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
